// File: rtl/custom_op_issue_if.sv
`default_nettype none
// ============================================================================
// Module      : custom_op_issue_if
// Description : Command, custom-unit and result signals of the issue stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface custom_op_issue_if #(
    parameter int DEPTH = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [3:0]               in_a;
    logic [3:0]               in_b;
    logic [1:0]               in_sel;
    logic [3:0]               cu_a;
    logic [3:0]               cu_b;
    logic [1:0]               cu_sel;
    logic [7:0]               cu_result;
    logic                     out_valid;
    logic                     out_ready;
    logic [7:0]               out_data;
    logic [1:0]               out_sel;
    logic [$clog2(DEPTH):0]   fifo_count;
    logic                     busy;
    logic [7:0]               done_count;

    modport slave (
        input  in_valid, in_a, in_b, in_sel, cu_result, out_ready,
        output in_ready, cu_a, cu_b, cu_sel, out_valid, out_data, out_sel,
               fifo_count, busy, done_count
    );

    modport master (
        output in_valid, in_a, in_b, in_sel, cu_result, out_ready,
        input  in_ready, cu_a, cu_b, cu_sel, out_valid, out_data, out_sel,
               fifo_count, busy, done_count
    );
endinterface
`default_nettype wire

// File: rtl/custom_op_issue.sv
`default_nettype none
// ============================================================================
// Module      : custom_op_issue
// Description : Command FIFO feeding the custom-ops unit, with a registered
//               valid/ready result slot.
// Revision    : 1.0 - initial release
// ============================================================================
module custom_op_issue #(
    parameter int DEPTH = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    custom_op_issue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] c_full_count = CW'(DEPTH);

    logic [9:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          out_valid_q;
    logic [7:0]    out_data_q;
    logic [1:0]    out_sel_q;
    logic [7:0]    done_q;

    logic          w_in_ready;
    logic          w_nonempty;
    logic          w_slot_free;
    logic          w_push;
    logic          w_pop;
    logic          w_handoff;
    logic          w_drive;
    logic [9:0]    w_head;

    // Full is judged on registered occupancy only, so a pop never frees a slot
    // for a push in the same cycle.
    assign w_in_ready  = !rst && (count_q < c_full_count);
    assign w_nonempty  = (count_q != '0);
    assign w_slot_free = !out_valid_q || bus.out_ready;
    assign w_push      = bus.in_valid && w_in_ready;
    assign w_pop       = w_nonempty && w_slot_free;
    assign w_handoff   = out_valid_q && bus.out_ready;
    assign w_head      = mem_q[rd_ptr_q];
    assign w_drive     = !rst && w_nonempty;

    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {bus.in_a, bus.in_b, bus.in_sel};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            done_q      <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
            if (w_pop) begin
                out_data_q  <= bus.cu_result;
                out_sel_q   <= w_head[1:0];
                out_valid_q <= 1'b1;
            end else if (w_handoff) begin
                out_valid_q <= 1'b0;
            end
            if (w_handoff) begin
                done_q <= done_q + 8'd1;
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.cu_a       = w_drive ? w_head[9:6] : 4'd0;
    assign bus.cu_b       = w_drive ? w_head[5:2] : 4'd0;
    assign bus.cu_sel     = w_drive ? w_head[1:0] : 2'd0;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_sel    = out_sel_q;
    assign bus.fifo_count = rst ? '0 : count_q;
    assign bus.busy       = !rst && (w_nonempty || out_valid_q);
    assign bus.done_count = done_q;
endmodule
`default_nettype wire

// File: tb/tb_custom_op_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_custom_op_issue
// Description : Directed self-checking bench for custom_op_issue (DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_custom_op_issue;
    logic clk = 1'b0;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;

    custom_op_issue_if #(.DEPTH(4)) bus ();

    custom_op_issue #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Stand-in for the combinational custom unit: 4-bit ops, zero-extended.
    function automatic logic [7:0] cu_model(input logic [3:0] a, input logic [3:0] b,
                                            input logic [1:0] sel);
        logic [3:0] t;
        logic [7:0] d;
        t = 4'd0;
        d = {a, a} << b[1:0];
        case (sel)
            2'd0:    t = a << b[1:0];
            2'd1:    t = a >> b[1:0];
            2'd2:    t = d[7:4];
            default: t = 4'($countones(a | b));
        endcase
        return {4'd0, t};
    endfunction

    assign bus.cu_result = cu_model(bus.cu_a, bus.cu_b, bus.cu_sel);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [1:0] sel);
        bus.in_a   = a;
        bus.in_b   = b;
        bus.in_sel = sel;
    endtask

    task automatic single(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic [1:0] sel, input logic [7:0] exp);
        bus.in_valid = 1'b1;
        drive(a, b, sel);
        tick();
        bus.in_valid = 1'b0;
        check({tag, "_count"}, 32'(bus.fifo_count), 1);
        check({tag, "_cu_sel"}, 32'(bus.cu_sel), 32'(sel));
        check({tag, "_early"}, 32'(bus.out_valid), 0);
        tick();
        check({tag, "_valid"}, 32'(bus.out_valid), 1);
        check({tag, "_data"}, 32'(bus.out_data), 32'(exp));
        check({tag, "_sel"}, 32'(bus.out_sel), 32'(sel));
        tick();
        check({tag, "_drained"}, 32'(bus.out_valid), 0);
    endtask

    logic [7:0] exp_s [20];
    logic [1:0] sel_s [20];
    logic [3:0] bp_a   [6] = '{4'b1011, 4'b1011, 4'b1000, 4'b0111, 4'b0001, 4'b1111};
    logic [3:0] bp_b   [6] = '{4'd1,    4'd3,    4'd2,    4'd0,    4'd3,    4'd1};
    logic [1:0] bp_sel [6] = '{2'd0,    2'd1,    2'd2,    2'd3,    2'd0,    2'd2};

    initial begin
        int  n_acc;
        logic acc;
        logic [3:0] sa;
        logic [3:0] sb;

        // Reset held with a command offered
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        drive(4'hA, 4'h1, 2'd2);
        repeat (3) tick();
        check("rst_in_ready", 32'(bus.in_ready), 0);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_data", 32'(bus.out_data), 0);
        check("rst_count", 32'(bus.fifo_count), 0);
        check("rst_done", 32'(bus.done_count), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_cu", {20'd0, bus.cu_a, bus.cu_b, bus.cu_sel}, 0);
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 1);

        // One op per select
        single("lsl", 4'b1011, 4'd2, 2'd0, 8'h0C);
        single("lsr", 4'b1011, 4'd2, 2'd1, 8'h02);
        single("rol", 4'b1011, 4'd1, 2'd2, 8'h07);
        single("pop", 4'b0101, 4'b1010, 2'd3, 8'h04);
        check("single_done", 32'(bus.done_count), 4);

        // Streaming: 20 back-to-back commands
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            sa       = i[3:0];
            sb       = 4'(i * 3);
            sel_s[i] = i[1:0];
            exp_s[i] = cu_model(sa, sb, sel_s[i]);
            drive(sa, sb, sel_s[i]);
            tick();
            check("stream_count", 32'(bus.fifo_count), 1);
            if (i > 0) begin
                check("stream_data", 32'(bus.out_data), 32'(exp_s[i-1]));
                check("stream_sel", 32'(bus.out_sel), 32'(sel_s[i-1]));
            end
        end
        bus.in_valid = 1'b0;
        tick();
        check("stream_last", 32'(bus.out_data), 32'(exp_s[19]));
        tick();
        check("stream_idle", 32'(bus.out_valid), 0);
        check("stream_done", 32'(bus.done_count), 24);

        // Backpressure: fill output slot plus FIFO
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        n_acc = 0;
        for (int t = 0; t < 8; t++) begin
            drive(bp_a[n_acc], bp_b[n_acc], bp_sel[n_acc]);
            acc = bus.in_ready;
            tick();
            if (acc) n_acc++;
        end
        check("bp_accepted", 32'(n_acc), 5);
        check("bp_in_ready", 32'(bus.in_ready), 0);
        check("bp_count", 32'(bus.fifo_count), 4);
        check("bp_valid", 32'(bus.out_valid), 1);
        check("bp_hold", 32'(bus.out_data), 32'h06);
        check("bp_busy", 32'(bus.busy), 1);

        // Drain at full: offered push refused on the popping edge
        bus.out_ready = 1'b1;
        #1;
        check("full_refuse", 32'(bus.in_ready), 0);
        tick();
        check("drainA_count", 32'(bus.fifo_count), 3);
        check("drainA_data", 32'(bus.out_data), 32'h01);
        check("drainA_in_ready", 32'(bus.in_ready), 1);
        check("drainA_done", 32'(bus.done_count), 25);
        tick();
        bus.in_valid = 1'b0;
        check("drainB_count", 32'(bus.fifo_count), 3);
        check("drainB_data", 32'(bus.out_data), 32'h02);
        tick();
        check("drainC_data", 32'(bus.out_data), 32'h03);
        check("drainC_count", 32'(bus.fifo_count), 2);
        tick();
        check("drainD_data", 32'(bus.out_data), 32'h08);
        tick();
        check("drainE_data", 32'(bus.out_data), 32'h0F);
        check("drainE_sel", 32'(bus.out_sel), 2);
        check("drainE_count", 32'(bus.fifo_count), 0);
        check("drainE_done", 32'(bus.done_count), 29);
        tick();
        check("drainF_valid", 32'(bus.out_valid), 0);
        check("drainF_done", 32'(bus.done_count), 30);
        check("drainF_busy", 32'(bus.busy), 0);

        // Reset during a stall with 3 queued
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sa = 4'(i + 1);
            drive(sa, 4'd0, 2'd0);
            tick();
        end
        bus.in_valid = 1'b0;
        check("mid_count", 32'(bus.fifo_count), 3);
        check("mid_valid", 32'(bus.out_valid), 1);
        rst = 1'b1;
        tick();
        check("mid_rst_count", 32'(bus.fifo_count), 0);
        check("mid_rst_valid", 32'(bus.out_valid), 0);
        check("mid_rst_data", 32'(bus.out_data), 0);
        check("mid_rst_done", 32'(bus.done_count), 0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 0);
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        drive(4'b0101, 4'd1, 2'd1);
        tick();
        bus.in_valid = 1'b0;
        check("fresh_count", 32'(bus.fifo_count), 1);
        tick();
        check("fresh_valid", 32'(bus.out_valid), 1);
        check("fresh_data", 32'(bus.out_data), 32'h02);
        tick();
        check("fresh_done", 32'(bus.done_count), 1);
        check("fresh_busy", 32'(bus.busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/custom_op_issue.md
# custom_op_issue

Issue/collect stage wrapped around the combinational custom-operations unit (shift/rotate/popcount) of the 4-bit ALU. It accepts operand/opcode commands over a valid/ready handshake and buffers them in a small FIFO. It drives the FIFO head onto the custom unit's inputs, then registers the unit's 8-bit result into a valid/ready output slot. It decouples the ALU front-end from result consumers, sustains one operation per cycle and applies backpressure in both directions.

## Interface
- DEPTH, 4, command FIFO entries; power of two, 2..16
- clk  in  1  rising-edge clock, the only clock
- rst  in  1  reset; synchronous and active-high
- in_valid  in  1  command present
- in_ready  out  1  FIFO can accept a command
- in_a  in  4  operand A
- in_b  in  4  operand B; bits [1:0] are the shift/rotate amount in the custom unit
- in_sel  in  2  op select: 00 lsl, 01 lsr, 10 rol, 11 popcount(A|B)
- cu_a  out  4  A to custom unit
- cu_b  out  4  B to custom unit
- cu_sel  out  2  select to custom unit
- cu_result  in  8  combinational result from custom unit
- out_valid  out  1  out_data holds an uncollected result
- out_ready  in  1  consumer accepts result
- out_data  out  8  registered result
- out_sel  out  2  opcode tag of out_data
- fifo_count  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
- busy  out  1  fifo_count!=0 or out_valid
- done_count  out  8  results handed off (out_valid & out_ready); wraps 255->0

## Operation
- Storage: circular FIFO, DEPTH x 10 bits {a,b,sel}, write pointer, read pointer and occupancy counter.
- Push when in_valid & in_ready.
  - in_ready = !rst & (fifo_count < DEPTH).
  - A full FIFO does not accept a push, even in a cycle where it pops.
- Head drive: cu_a/cu_b/cu_sel come from the FIFO head entry (register outputs, muxed by read pointer). When the FIFO is empty they are 0.
- Output slot is free when !out_valid | out_ready.
- Capture: when fifo_count!=0 and the slot is free:
  - out_data <= cu_result, out_sel <= head sel, out_valid <= 1;
  - FIFO pops.
- Drain: when out_valid & out_ready and there is no capture, out_valid <= 0.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- done_count increments on every out_valid & out_ready.
- out_data/out_sel hold stable while out_valid & !out_ready.
- No combinational path from in_* to out_*. in_ready depends only on registered state and rst.

## Timing
- Reset (rst high at a clock edge) clears the FIFO, pointers, out_valid, out_data, out_sel and done_count to 0.
  - During reset: fifo_count=0, busy=0, cu_*=0, in_ready=0.
  - Entries in flight are discarded, with no handoff.
  - First push is possible in the first cycle after rst deasserts.
- Latency: a command pushed at edge k becomes head in cycle k+1. If the slot is free, its result is captured at edge k+1 and out_valid is high in cycle k+2. Minimum latency is 2 cycles.
- Throughput: 1 result/cycle with in_valid and out_ready held high. fifo_count then stays at 1.
- Backpressure capacity: 1 (output slot) + DEPTH (FIFO) commands are accepted before in_ready falls.
- Ordering: results leave in strict push order.

## Test plan
- Reset check: rst high 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, out_data=0x00, fifo_count=0, done_count=0, cu_*=0.
- Single op per select, each pushed alone with out_ready=1. Expected out_data two cycles after push:
  - A=4'b1011, B=2, sel 00 -> 0x0C;
  - A=4'b1011, B=2, sel 01 -> 0x02;
  - A=4'b1011, B=1, sel 10 -> 0x07;
  - A=4'b0101, B=4'b1010, sel 11 -> 0x04;
  - out_sel matches each opcode.
- Streaming: 20 back-to-back pushes with out_ready=1 -> 20 results in order, one per cycle from cycle 2 on, done_count=20, fifo_count never exceeds 1.
- Backpressure (DEPTH=4): out_ready=0, in_valid held -> exactly 5 commands accepted, then in_ready=0 with fifo_count=4. out_data stays equal to the first result. Raising out_ready drains all 5 in order over 5 cycles, and in_ready returns the cycle after the first pop.
- Simultaneous push/pop at full: with fifo_count=4 and out_ready=1, the push is refused and fifo_count goes to 3. The next cycle's push is accepted.
- Reset mid-operation: rst during a stall with 3 entries queued and out_valid=1 -> all state cleared next cycle. A fresh command gives its result 2 cycles after push and done_count=1.
